// File: rtl/lenet_frame_reader.sv
// Reads the cropped camera image from the frame buffer, zero-pads it to OUT_W x OUT_W,
// applies optional invert/threshold and streams pixels over valid/ready to the first conv layer.
module lenet_frame_reader #(
  parameter int IMG_W = 28,
  parameter int PAD   = 2,
  parameter int AW    = 10,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          invert_en,
  input  logic          thresh_en,
  input  logic [DW-1:0] thresh,
  output logic [AW-1:0] aa_frame_buf,
  output logic          cena_frame_buf,
  input  logic [DW-1:0] qa_frame_buf,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          pix_sof,
  output logic          pix_eol,
  output logic          pix_eof,
  output logic          busy,
  output logic          done,
  output logic [1:0]    dbg_state
);

  localparam int OUT_W = IMG_W + 2 * PAD;
  localparam int CW    = $clog2(OUT_W);
  localparam int FW    = DW + 3;
  localparam logic [CW-1:0] LO   = CW'(PAD);
  localparam logic [CW-1:0] HI   = CW'(PAD + IMG_W);
  localparam logic [CW-1:0] LAST = CW'(OUT_W - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_e;

  // Stream handshake: a pixel transfers on every rising edge where pix_valid & pix_ready;
  // while pix_valid & !pix_ready the pix_* outputs hold, and pix_valid never drops without a transfer.
  state_e          state_q, state_d;
  logic [CW-1:0]   ox_q, ox_d, oy_q, oy_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic            invert_q, invert_d, thr_en_q, thr_en_d;
  logic [DW-1:0]   thr_q, thr_d;
  logic            pipe_vld_q, pipe_vld_d, pipe_pad_q, pipe_pad_d;
  logic [2:0]      pipe_flags_q, pipe_flags_d;
  logic [FW-1:0]   fifo_q [2];
  logic [FW-1:0]   fifo_d [2];
  logic            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;

  logic            issue, interior, last_slot, pop, push, frame_end;
  logic [1:0]      credit_used;
  logic [DW-1:0]   pix_val;
  logic [FW-1:0]   head;

  always_comb begin
    state_d      = state_q;
    ox_d         = ox_q;
    oy_d         = oy_q;
    rd_addr_d    = rd_addr_q;
    invert_d     = invert_q;
    thr_en_d     = thr_en_q;
    thr_d        = thr_q;
    fifo_d       = fifo_q;

    pop       = (count_q != 2'd0) && pix_ready;
    push      = pipe_vld_q;
    // A slot popped this cycle frees its credit immediately, keeping one pixel per clock.
    credit_used = count_q - {1'b0, pop} + {1'b0, pipe_vld_q};
    interior  = (ox_q >= LO) && (ox_q < HI) && (oy_q >= LO) && (oy_q < HI);
    last_slot = (ox_q == LAST) && (oy_q == LAST);
    issue     = (state_q == ISSUE) && (credit_used < 2'd2);
    frame_end = (state_q == DRAIN) && (count_q == 2'd0) && !pipe_vld_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ISSUE;
          ox_d      = '0;
          oy_d      = '0;
          rd_addr_d = '0;
          invert_d  = invert_en;
          thr_en_d  = thresh_en;
          thr_d     = thresh;
        end
      end
      ISSUE: begin
        if (issue) begin
          if (interior) rd_addr_d = rd_addr_q + AW'(1);
          if (ox_q == LAST) begin
            ox_d = '0;
            oy_d = oy_q + CW'(1);
          end else begin
            ox_d = ox_q + CW'(1);
          end
          if (last_slot) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (frame_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Border slots travel through the same one-cycle stage as reads so order is preserved.
    pipe_vld_d   = issue;
    pipe_pad_d   = !interior;
    pipe_flags_d = {(ox_q == '0) && (oy_q == '0), ox_q == LAST, last_slot};

    pix_val = invert_q ? ~qa_frame_buf : qa_frame_buf;
    if (thr_en_q) pix_val = (pix_val >= thr_q) ? '1 : '0;
    if (pipe_pad_q) pix_val = '0;

    if (push) fifo_d[wr_ptr_q] = {pix_val, pipe_flags_q};
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      ox_q         <= '0;
      oy_q         <= '0;
      rd_addr_q    <= '0;
      invert_q     <= 1'b0;
      thr_en_q     <= 1'b0;
      thr_q        <= '0;
      pipe_vld_q   <= 1'b0;
      pipe_pad_q   <= 1'b0;
      pipe_flags_q <= '0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      rd_addr_q    <= rd_addr_d;
      invert_q     <= invert_d;
      thr_en_q     <= thr_en_d;
      thr_q        <= thr_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_pad_q   <= pipe_pad_d;
      pipe_flags_q <= pipe_flags_d;
      fifo_q[0]    <= fifo_d[0];
      fifo_q[1]    <= fifo_d[1];
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign head           = fifo_q[rd_ptr_q];
  assign pix_valid      = (count_q != 2'd0);
  assign pix_data       = pix_valid ? head[FW-1:3] : '0;
  assign pix_sof        = pix_valid & head[2];
  assign pix_eol        = pix_valid & head[1];
  assign pix_eof        = pix_valid & head[0];
  assign aa_frame_buf   = rd_addr_q;
  assign cena_frame_buf = !(issue && interior);
  assign busy           = (state_q != IDLE);
  assign done           = frame_end;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_lenet_frame_reader.sv
// Bench for lenet_frame_reader: frame-level vector table with a pixel scoreboard,
// plus hand sequences for mid-frame reset, restart and long stalls.
module tb_lenet_frame_reader;

  localparam int IMG_W = 28;
  localparam int PAD   = 2;
  localparam int OUT_W = IMG_W + 2 * PAD;
  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int NPIX  = OUT_W * OUT_W;
  localparam int NRD   = IMG_W * IMG_W;
  localparam int BUDGET = 20000;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          invert_en = 1'b0;
  logic          thresh_en = 1'b0;
  logic [DW-1:0] thresh = '0;
  logic [AW-1:0] aa_frame_buf;
  logic          cena_frame_buf;
  logic [DW-1:0] qa_frame_buf = '0;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic          pix_sof, pix_eol, pix_eof, busy, done;
  logic [1:0]    dbg_state;

  lenet_frame_reader #(.IMG_W(IMG_W), .PAD(PAD), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .invert_en(invert_en),
    .thresh_en(thresh_en), .thresh(thresh), .aa_frame_buf(aa_frame_buf),
    .cena_frame_buf(cena_frame_buf), .qa_frame_buf(qa_frame_buf),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       inv;
    logic       te;
    logic [7:0] th;
    int         pat;
    int         rdy;
    int         px;
    int         py;
    logic [7:0] pexp;
    int         stall_at;
    int         stall_len;
    int         restart_at;
  } vec_t;

  vec_t vecs[11];

  logic [DW-1:0]   mem [0:(1<<AW)-1];
  logic [DW+2:0]   exp_q[$];
  int checks = 0;
  int errors = 0;

  int hs_count, rd_count, exp_addr, valid_cycles, done_count, probe_idx;
  int stall_cycle, stall_reads, late_reads;
  int ready_pct = 100;
  logic stall = 1'b0;
  logic mon_en = 1'b0;
  logic expect_done = 1'b0;
  logic prev_stall_v = 1'b0;
  logic [DW+2:0] prev_word;
  logic [DW-1:0] probe_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // frame buffer: one-cycle read latency, active-low enable
  always @(posedge clk) if (!cena_frame_buf) qa_frame_buf <= mem[aa_frame_buf];

  initial forever begin
    @(posedge clk);
    #1;
    pix_ready = !stall && ($urandom_range(0, 99) < ready_pct);
  end

  function automatic logic [DW+2:0] model(input int x, input int y, input logic inv,
                                          input logic te, input logic [DW-1:0] th);
    logic [DW-1:0] v;
    int a;
    v = '0;
    if (x >= PAD && x < PAD + IMG_W && y >= PAD && y < PAD + IMG_W) begin
      a = (y - PAD) * IMG_W + (x - PAD);
      v = mem[a];
      if (inv) v = 8'hFF - v;
      if (te) v = (v >= th) ? 8'hFF : 8'h00;
    end
    return {v, (x == 0 && y == 0), (x == OUT_W - 1), (x == OUT_W - 1 && y == OUT_W - 1)};
  endfunction

  always @(negedge clk) begin
    logic [DW+2:0] word;
    if (mon_en) begin
      word = {pix_data, pix_sof, pix_eol, pix_eof};
      if (prev_stall_v) check("stall_hold", {pix_valid, word}, {1'b1, prev_word});
      prev_stall_v = pix_valid && !pix_ready;
      prev_word = word;
      if (expect_done) begin
        check("done_after_eof", done, 1);
        expect_done = 1'b0;
      end else if (done) begin
        check("done_spurious", done, 0);
      end
      if (done) done_count++;
      if (pix_valid) valid_cycles++;
      if (stall) stall_cycle++;
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra_pixel actual=%0h required=none", word);
        end else begin
          check("pixel", word, exp_q.pop_front());
        end
        if (hs_count == probe_idx) probe_val = pix_data;
        hs_count++;
        if (pix_eof) expect_done = 1'b1;
      end
      if (!cena_frame_buf) begin
        check("rd_addr", aa_frame_buf, exp_addr);
        exp_addr++;
        rd_count++;
        if (stall) stall_reads++;
        if (stall && stall_cycle > 4) late_reads++;
      end
    end
  end

  task automatic load_frame(input int pat, input logic inv, input logic te, input logic [7:0] th);
    for (int a = 0; a < (1 << AW); a++) begin
      case (pat)
        1:       mem[a] = 8'h10;
        2:       mem[a] = a[0] ? 8'h80 : 8'h7F;
        default: mem[a] = a[7:0];
      endcase
    end
    exp_q.delete();
    for (int y = 0; y < OUT_W; y++)
      for (int x = 0; x < OUT_W; x++)
        exp_q.push_back(model(x, y, inv, te, th));
    hs_count = 0; rd_count = 0; exp_addr = 0; valid_cycles = 0; done_count = 0;
    stall_cycle = 0; stall_reads = 0; late_reads = 0;
    expect_done = 1'b0; prev_stall_v = 1'b0; probe_val = 'x;
    mon_en = 1'b1;
  endtask

  task automatic pulse_start(input logic inv, input logic te, input logic [7:0] th);
    @(posedge clk); #1;
    start = 1'b1; invert_en = inv; thresh_en = te; thresh = th;
    @(posedge clk); #1;
    start = 1'b0; invert_en = ~inv; thresh_en = ~te; thresh = ~th;
  endtask

  task automatic run_frame(input vec_t v);
    int cyc;
    bit stalled, restarted;
    cyc = 0; stalled = 0; restarted = 0;
    ready_pct = v.rdy;
    probe_idx = v.py * OUT_W + v.px;
    load_frame(v.pat, v.inv, v.te, v.th);
    if (v.stall_at == 0) begin
      stall = 1'b1;
      stalled = 1;
    end
    pulse_start(v.inv, v.te, v.th);
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("valid_lat1", pix_valid, 0);
    @(negedge clk);
    check("valid_lat2", pix_valid, 0);
    @(negedge clk);
    check("valid_lat3", pix_valid, 1);
    while (done_count == 0 && cyc < BUDGET) begin
      @(negedge clk); #2;
      cyc++;
      start = 1'b0;
      if (!restarted && v.restart_at > 0 && hs_count >= v.restart_at) begin
        start = 1'b1;
        restarted = 1;
      end
      if (!stalled && v.stall_at > 0 && hs_count >= v.stall_at) begin
        stall = 1'b1;
        stalled = 1;
      end
      if (stall && stall_cycle >= v.stall_len) begin
        check("stall_valid", pix_valid, 1);
        if (v.stall_at == 0) check("stall_sof", pix_sof, 1);
        check("stall_no_late_reads", late_reads, 0);
        check("stall_reads_le2", stall_reads <= 2, 1);
        stall = 1'b0;
      end
    end
    start = 1'b0;
    if (cyc >= BUDGET) begin
      errors++;
      $display("FAIL frame_timeout actual=%0d pixels required=%0d", hs_count, NPIX);
    end
    check("pixel_count", hs_count, NPIX);
    check("read_count", rd_count, NRD);
    check("sb_left", exp_q.size(), 0);
    check("probe_pixel", probe_val, v.pexp);
    if (v.rdy == 100 && v.stall_at < 0) check("valid_cycles", valid_cycles, NPIX);
    @(negedge clk);
    check("busy_after_done", busy, 0);
  endtask

  task automatic run_abort();
    int cyc;
    cyc = 0;
    ready_pct = 100;
    stall = 1'b0;
    load_frame(0, 1'b0, 1'b0, 8'h00);
    pulse_start(1'b0, 1'b0, 8'h00);
    while (hs_count < 500 && cyc < BUDGET) begin
      @(negedge clk); #2;
      cyc++;
    end
    if (cyc >= BUDGET) begin
      errors++;
      $display("FAIL abort_timeout actual=%0d pixels required=500", hs_count);
    end
    rstn = 1'b0;
    mon_en = 1'b0;
    #1;
    check("abort_valid", pix_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_cena", cena_frame_buf, 1);
    check("abort_done", done, 0);
    check("abort_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("post_reset_idle", {pix_valid, ~cena_frame_buf, busy}, 0);
    end
  endtask

  initial begin
    //           inv   te    th     pat rdy px  py  pexp   stall len restart
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 0, 100, 2,  2,  8'h00, -1,   0,  -1};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 0, 100, 3,  2,  8'h01, -1,   0,  -1};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 0, 100, 29, 29, 8'h0F, -1,   0,  -1};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 0, 100, 31, 15, 8'h00, -1,   0,  -1};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 1, 100, 5,  10, 8'hEF, -1,   0,  -1};
    vecs[5]  = '{1'b1, 1'b0, 8'h00, 1, 100, 0,  0,  8'h00, -1,   0,  -1};
    vecs[6]  = '{1'b0, 1'b1, 8'h80, 2, 100, 2,  2,  8'h00, -1,   0,  -1};
    vecs[7]  = '{1'b0, 1'b1, 8'h80, 2, 100, 3,  2,  8'hFF, -1,   0,  -1};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 0, 30,  29, 29, 8'h0F, -1,   0,  300};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 0, 100, 10, 3,  8'h24, 100,  100, -1};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 0, 100, 0,  0,  8'h00, 0,    100, -1};

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_aa", aa_frame_buf, 0);
    check("rst_cena", cena_frame_buf, 1);
    check("rst_valid", pix_valid, 0);
    check("rst_data", pix_data, 0);
    check("rst_flags", {pix_sof, pix_eol, pix_eof}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++) run_frame(vecs[i]);

    run_abort();
    run_frame(vecs[2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
